runway_allocation_unit: RTL and testbench
=========================================

Name: runway_allocation_unit

Overview:
- Downstream consumer of the weather/emergency unit: takes its `ECSU_state` and `emergency_landing_alert`, and arbitrates a single runway between landing and takeoff requests.
- Requests are queued per type in two FIFOs. The runway is granted to one aircraft at a time, and occupancy is timed.
- Weather state gates takeoffs. Landings always have priority.

Parameters:
- QUEUE_DEPTH, 4, entries per FIFO (landing and takeoff). Legal range 1..7.
- RUNWAY_TIME, 8, cycles the runway stays occupied per grant. Must be ≥ 1.
- ID_W, 4, aircraft ID width.

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset
- req_valid  in  1  request strobe; one request per cycle
- req_type  in  1  0 = landing, 1 = takeoff
- req_id  in  ID_W  aircraft ID
- ECSU_state  in  2  00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY
- emergency_landing_alert  in  1  emergency flag from the weather unit
- req_accept  out  1  1-cycle pulse: previous-cycle request enqueued
- req_reject  out  1  1-cycle pulse: previous-cycle request refused
- grant_valid  out  1  1-cycle pulse: runway granted
- grant_type  out  1  type of current/last grant
- grant_id  out  ID_W  ID of current/last grant
- runway_busy  out  1  runway occupied
- landing_count  out  3  landing FIFO occupancy
- takeoff_count  out  3  takeoff FIFO occupancy
- ARTAU_state  out  2  00 IDLE, 01 LANDING, 10 TAKEOFF (11 unused)

Behaviour:

Reset and registers:
- Single clock.
- Reset is synchronous and active-high, named RST, on clock CLK.
- RST=1 at a posedge clears everything: both FIFOs, timer, `ARTAU_state`=IDLE, and all outputs to 0.
- This holds mid-operation: a runway in use is released immediately.
- All outputs are registered.

Request acceptance (evaluated at posedge with `req_valid`=1):
- Takeoff is barred if `ECSU_state` ≥ 10 or `emergency_landing_alert`=1.
- The request is rejected if its FIFO count (pre-edge value) equals QUEUE_DEPTH, or if it is a barred takeoff. Otherwise it is pushed at the tail.
- The response is next cycle: exactly one of `req_accept`/`req_reject` pulses for one cycle. Both are 0 when no request was made.
- A push to a FIFO being popped at the same edge is allowed only if the pre-edge count < QUEUE_DEPTH. No pass-through.

Takeoff flush:
- While `ECSU_state`=11, the takeoff FIFO is cleared every edge; `takeoff_count`=0.
- A takeoff request arriving in that cycle is rejected.

State machine (IDLE / LANDING / TAKEOFF):
- IDLE: if `landing_count` > 0, pop the landing head.
- Else, if `takeoff_count` > 0 and takeoff is not barred, pop the takeoff head.
- On a pop, at that same edge:
  - `grant_valid`←1
  - `grant_type`/`grant_id`←popped entry
  - `runway_busy`←1
  - timer←RUNWAY_TIME−1
  - state←LANDING or TAKEOFF
- LANDING/TAKEOFF: at each edge, if timer=0 go to IDLE with `runway_busy`←0; else timer−1.
- `runway_busy` is therefore high for exactly RUNWAY_TIME cycles.
- After release there is at least one IDLE cycle before the next grant.
- A takeoff in progress is never aborted by a weather change (except RST).
- `grant_valid` is high exactly one cycle per grant.
- `grant_id`/`grant_type` hold their value until the next grant.

Queue rules:
- FIFO order is strict within each queue.
- Pointers wrap modulo QUEUE_DEPTH.
- Counts never exceed QUEUE_DEPTH and never underflow.

Test Plan:
1. RST, then landing request id=3 at ALL_CLEAR → `req_accept` pulse. The next IDLE edge gives `grant_valid`, `grant_type`=0, `grant_id`=3. `runway_busy` is high for exactly 8 cycles, then `ARTAU_state`=00.
2. Queue takeoff id=5, then landing id=7, while idle and blocked by a running grant → after release, id=7 (landing) is granted first, then id=5 after a further 8 busy cycles plus 1 idle cycle.
3. Five landing requests id=1..5 back-to-back while the runway is busy → 4 accepts then 1 reject. `landing_count`=4. Grants come out in order 1,2,3,4.
4. `ECSU_state`=10, takeoff request id=9 → `req_reject`. Landing request id=2 → accepted and granted. Takeoff queued at 00, then `ECSU_state`→10 → no takeoff grant until the state returns to ≤01.
5. Two takeoffs queued, then `ECSU_state`=11 → `takeoff_count`=0 at the next edge. A takeoff already granted completes its full 8 cycles.
6. RST asserted during LANDING with timer=4 and 2 entries queued → at the next edge all counts are 0, `runway_busy`=0, `ARTAU_state`=00, and no `grant_valid` follows.

Source files
------------

// File: rtl/runway_allocation_unit_if.sv
// Request/grant bundle between the runway allocation unit and its environment.
// The master side issues requests and weather inputs; the slave side returns responses, grants and status.
interface runway_allocation_unit_if #(
  parameter int ID_W = 4
);
  logic            req_valid;
  logic            req_type;
  logic [ID_W-1:0] req_id;
  logic [1:0]      ECSU_state;
  logic            emergency_landing_alert;

  logic            req_accept;
  logic            req_reject;
  logic            grant_valid;
  logic            grant_type;
  logic [ID_W-1:0] grant_id;
  logic            runway_busy;
  logic [2:0]      landing_count;
  logic [2:0]      takeoff_count;
  logic [1:0]      ARTAU_state;

  modport master (
    output req_valid, req_type, req_id, ECSU_state, emergency_landing_alert,
    input  req_accept, req_reject, grant_valid, grant_type, grant_id,
           runway_busy, landing_count, takeoff_count, ARTAU_state
  );

  modport slave (
    input  req_valid, req_type, req_id, ECSU_state, emergency_landing_alert,
    output req_accept, req_reject, grant_valid, grant_type, grant_id,
           runway_busy, landing_count, takeoff_count, ARTAU_state
  );
endinterface

// File: rtl/runway_allocation_unit.sv
// Single-runway arbiter: queues landing/takeoff requests in two FIFOs and grants the runway
// for a fixed occupancy time, landings first, with takeoffs gated by the weather state.
module runway_allocation_unit #(
  parameter int QUEUE_DEPTH = 4,
  parameter int RUNWAY_TIME = 8,
  parameter int ID_W        = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  runway_allocation_unit_if.slave bus
);

  localparam int         TW      = (RUNWAY_TIME > 1) ? $clog2(RUNWAY_TIME) : 1;
  localparam logic [2:0] DEPTH_C = 3'(QUEUE_DEPTH);
  localparam logic [2:0] LAST_C  = 3'(QUEUE_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LANDING = 2'b01,
    TAKEOFF = 2'b10
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;

  logic [ID_W-1:0] land_mem [8];
  logic [ID_W-1:0] take_mem [8];
  logic [2:0]      land_wr, land_rd, land_cnt;
  logic [2:0]      take_wr, take_rd, take_cnt;

  logic            accept_q, reject_q, grant_valid_q, grant_type_q, busy_q;
  logic [ID_W-1:0] grant_id_q;

  logic            takeoff_barred, takeoff_flush;
  logic            push_land, push_take, pop_land, pop_take;
  logic            busy_next, grant_next;

  function automatic logic [2:0] ptr_inc(input logic [2:0] ptr);
    return (ptr == LAST_C) ? 3'd0 : ptr + 3'd1;
  endfunction

  assign takeoff_barred = bus.ECSU_state[1] | bus.emergency_landing_alert;
  assign takeoff_flush  = (bus.ECSU_state == 2'b11);

  // Fullness uses the pre-edge count, so a push never rides on a same-edge pop.
  assign push_land = bus.req_valid & ~bus.req_type & (land_cnt != DEPTH_C);
  assign push_take = bus.req_valid &  bus.req_type & (take_cnt != DEPTH_C) & ~takeoff_barred;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    pop_land   = 1'b0;
    pop_take   = 1'b0;
    busy_next  = busy_q;
    grant_next = 1'b0;
    case (state)
      IDLE: begin
        if (land_cnt != 3'd0) begin
          pop_land   = 1'b1;
          grant_next = 1'b1;
          busy_next  = 1'b1;
          timer_next = TW'(RUNWAY_TIME - 1);
          state_next = LANDING;
        end else if (take_cnt != 3'd0 && !takeoff_barred) begin
          pop_take   = 1'b1;
          grant_next = 1'b1;
          busy_next  = 1'b1;
          timer_next = TW'(RUNWAY_TIME - 1);
          state_next = TAKEOFF;
        end
      end
      LANDING, TAKEOFF: begin
        if (timer == '0) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      accept_q      <= 1'b0;
      reject_q      <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_type_q  <= 1'b0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      accept_q      <= push_land | push_take;
      reject_q      <= bus.req_valid & ~(push_land | push_take);
      grant_valid_q <= grant_next;
      busy_q        <= busy_next;
      if (pop_land) begin
        grant_type_q <= 1'b0;
        grant_id_q   <= land_mem[land_rd];
      end else if (pop_take) begin
        grant_type_q <= 1'b1;
        grant_id_q   <= take_mem[take_rd];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      land_wr  <= 3'd0;
      land_rd  <= 3'd0;
      land_cnt <= 3'd0;
    end else begin
      if (push_land) begin
        land_mem[land_wr] <= bus.req_id;
        land_wr           <= ptr_inc(land_wr);
      end
      if (pop_land)
        land_rd <= ptr_inc(land_rd);
      land_cnt <= land_cnt + {2'b00, push_land} - {2'b00, pop_land};
    end
  end

  // An emergency empties the takeoff queue on every edge it is present.
  always_ff @(posedge CLK) begin
    if (RST || takeoff_flush) begin
      take_wr  <= 3'd0;
      take_rd  <= 3'd0;
      take_cnt <= 3'd0;
    end else begin
      if (push_take) begin
        take_mem[take_wr] <= bus.req_id;
        take_wr           <= ptr_inc(take_wr);
      end
      if (pop_take)
        take_rd <= ptr_inc(take_rd);
      take_cnt <= take_cnt + {2'b00, push_take} - {2'b00, pop_take};
    end
  end

  assign bus.req_accept    = accept_q;
  assign bus.req_reject    = reject_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_type    = grant_type_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.runway_busy   = busy_q;
  assign bus.landing_count = land_cnt;
  assign bus.takeoff_count = take_cnt;
  assign bus.ARTAU_state   = state;

endmodule

// File: tb/tb_runway_allocation_unit.sv
// Directed self-checking bench for runway_allocation_unit with hand-computed expectations
// for request handling, landing priority, weather gating, takeoff flush and mid-grant reset.
module tb_runway_allocation_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   busyTally = 0;
  int   grantTally = 0;
  int   n;

  runway_allocation_unit_if #(.ID_W(4)) bus ();

  runway_allocation_unit #(
    .QUEUE_DEPTH(4),
    .RUNWAY_TIME(8),
    .ID_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one edge and sample 1 time unit later, tallying busy and grant cycles.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.runway_busy) busyTally++;
    if (bus.grant_valid) grantTally++;
  endtask

  task automatic applyStimulus(input logic rtype, input logic [3:0] id);
    bus.req_valid = 1'b1;
    bus.req_type  = rtype;
    bus.req_id    = id;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic waitGrant(input int maxTicks, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!bus.grant_valid && ticks < maxTicks);
    if (!bus.grant_valid) checkOutput("grant_timeout", int'(bus.grant_valid), 1);
  endtask

  task automatic waitIdle(input int maxTicks);
    int t = 0;
    while ((bus.runway_busy || bus.ARTAU_state != 2'b00) && t < maxTicks) begin
      tick();
      t++;
    end
    if (bus.runway_busy) checkOutput("idle_timeout", int'(bus.runway_busy), 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_type  = 1'b0;
    bus.req_id    = 4'd0;
    bus.ECSU_state = 2'b00;
    bus.emergency_landing_alert = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_accept", int'(bus.req_accept), 0);
    checkOutput("rst_grant_valid", int'(bus.grant_valid), 0);
    checkOutput("rst_busy", int'(bus.runway_busy), 0);
    checkOutput("rst_lcount", int'(bus.landing_count), 0);
    checkOutput("rst_state", int'(bus.ARTAU_state), 0);
    RST = 1'b0;

    // 1: single landing
    applyStimulus(1'b0, 4'd3);
    checkOutput("t1_accept", int'(bus.req_accept), 1);
    checkOutput("t1_reject", int'(bus.req_reject), 0);
    checkOutput("t1_lcount", int'(bus.landing_count), 1);
    busyTally = 0;
    grantTally = 0;
    waitGrant(5, n);
    checkOutput("t1_latency", n, 1);
    checkOutput("t1_accept_clear", int'(bus.req_accept), 0);
    checkOutput("t1_gtype", int'(bus.grant_type), 0);
    checkOutput("t1_gid", int'(bus.grant_id), 3);
    checkOutput("t1_state_landing", int'(bus.ARTAU_state), 1);
    waitIdle(20);
    checkOutput("t1_busy_cycles", busyTally, 8);
    checkOutput("t1_grant_pulses", grantTally, 1);
    checkOutput("t1_state_idle", int'(bus.ARTAU_state), 0);
    checkOutput("t1_gid_hold", int'(bus.grant_id), 3);

    // 2: landing priority over an earlier takeoff
    applyStimulus(1'b0, 4'd11);
    waitGrant(5, n);
    checkOutput("t2_gid_blocker", int'(bus.grant_id), 11);
    applyStimulus(1'b1, 4'd5);
    checkOutput("t2_accept_to", int'(bus.req_accept), 1);
    applyStimulus(1'b0, 4'd7);
    checkOutput("t2_accept_ld", int'(bus.req_accept), 1);
    checkOutput("t2_tcount", int'(bus.takeoff_count), 1);
    waitGrant(20, n);
    checkOutput("t2_first_gid", int'(bus.grant_id), 7);
    checkOutput("t2_first_gtype", int'(bus.grant_type), 0);
    waitGrant(20, n);
    checkOutput("t2_second_gid", int'(bus.grant_id), 5);
    checkOutput("t2_second_gtype", int'(bus.grant_type), 1);
    checkOutput("t2_gap", n, 9);
    checkOutput("t2_state_takeoff", int'(bus.ARTAU_state), 2);
    waitIdle(20);

    // 3: landing queue overflow and ordering
    applyStimulus(1'b0, 4'd12);
    waitGrant(5, n);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 4'(i));
      checkOutput($sformatf("t3_accept_%0d", i), int'(bus.req_accept), (i <= 4) ? 1 : 0);
      checkOutput($sformatf("t3_reject_%0d", i), int'(bus.req_reject), (i <= 4) ? 0 : 1);
    end
    checkOutput("t3_lcount_full", int'(bus.landing_count), 4);
    for (int i = 1; i <= 4; i++) begin
      waitGrant(20, n);
      checkOutput($sformatf("t3_order_%0d", i), int'(bus.grant_id), i);
    end
    waitIdle(20);
    checkOutput("t3_lcount_empty", int'(bus.landing_count), 0);

    // 4: weather gating of takeoffs
    bus.ECSU_state = 2'b10;
    applyStimulus(1'b1, 4'd9);
    checkOutput("t4_reject_to", int'(bus.req_reject), 1);
    checkOutput("t4_tcount", int'(bus.takeoff_count), 0);
    applyStimulus(1'b0, 4'd2);
    checkOutput("t4_accept_ld", int'(bus.req_accept), 1);
    waitGrant(5, n);
    checkOutput("t4_gid_ld", int'(bus.grant_id), 2);
    waitIdle(20);
    bus.ECSU_state = 2'b00;
    applyStimulus(1'b1, 4'd6);
    checkOutput("t4_accept_to", int'(bus.req_accept), 1);
    bus.ECSU_state = 2'b10;
    grantTally = 0;
    for (int i = 0; i < 12; i++) tick();
    checkOutput("t4_no_grant", grantTally, 0);
    checkOutput("t4_tcount_held", int'(bus.takeoff_count), 1);
    bus.ECSU_state = 2'b01;
    busyTally = 0;
    waitGrant(5, n);
    checkOutput("t4_release_latency", n, 1);
    checkOutput("t4_gid_to", int'(bus.grant_id), 6);
    checkOutput("t4_gtype_to", int'(bus.grant_type), 1);

    // 5: emergency flush while a takeoff runs
    applyStimulus(1'b1, 4'd13);
    applyStimulus(1'b1, 4'd14);
    checkOutput("t5_tcount_two", int'(bus.takeoff_count), 2);
    bus.emergency_landing_alert = 1'b1;
    applyStimulus(1'b1, 4'd15);
    checkOutput("t5_alert_reject", int'(bus.req_reject), 1);
    bus.emergency_landing_alert = 1'b0;
    bus.ECSU_state = 2'b11;
    applyStimulus(1'b1, 4'd8);
    checkOutput("t5_flush_reject", int'(bus.req_reject), 1);
    checkOutput("t5_tcount_flushed", int'(bus.takeoff_count), 0);
    checkOutput("t5_state_takeoff", int'(bus.ARTAU_state), 2);
    waitIdle(20);
    checkOutput("t5_busy_cycles", busyTally, 8);
    bus.ECSU_state = 2'b00;

    // 6: reset in the middle of a landing
    applyStimulus(1'b0, 4'd1);
    waitGrant(5, n);
    applyStimulus(1'b0, 4'd10);
    applyStimulus(1'b0, 4'd11);
    tick();
    checkOutput("t6_lcount_pre", int'(bus.landing_count), 2);
    checkOutput("t6_busy_pre", int'(bus.runway_busy), 1);
    RST = 1'b1;
    tick();
    checkOutput("t6_lcount", int'(bus.landing_count), 0);
    checkOutput("t6_tcount", int'(bus.takeoff_count), 0);
    checkOutput("t6_busy", int'(bus.runway_busy), 0);
    checkOutput("t6_state", int'(bus.ARTAU_state), 0);
    checkOutput("t6_gid", int'(bus.grant_id), 0);
    RST = 1'b0;
    grantTally = 0;
    for (int i = 0; i < 12; i++) tick();
    checkOutput("t6_no_grant", grantTally, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
